// File: rtl/mult_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mult_sequencer: shift-add controller for signed 8x8 multiply into {X,A,B} |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mult_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_x;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [2:0]       r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_last;
  logic [WIDTH-1:0] w_mop;
  logic [WIDTH:0]   w_sum;

  // The multiplier's top bit carries negative weight, so the last partial product is subtracted.
  assign w_last = (r_cnt == 3'd7);
  assign w_mop  = w_last ? ~r_m : r_m;
  assign w_sum  = {r_a[WIDTH-1], r_a} + {w_mop[WIDTH-1], w_mop} + {{WIDTH{1'b0}}, w_last};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_x     <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_cnt   <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Run) begin
            r_x     <= 1'b0;
            r_a     <= '0;
            r_m     <= S;
            r_cnt   <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= ST_CLEAR;
          end else if (ClearA_LoadB) begin
            r_x <= 1'b0;
            r_a <= '0;
            r_b <= S;
          end
        end
        ST_CLEAR: r_state <= ST_ADD;
        ST_ADD: begin
          if (r_b[0]) begin
            r_x <= w_sum[WIDTH];
            r_a <= w_sum[WIDTH-1:0];
          end
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_a <= {r_x, r_a[WIDTH-1:1]};
          r_b <= {r_a[0], r_b[WIDTH-1:1]};
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            r_cnt   <= r_cnt + 3'd1;
            r_state <= ST_ADD;
          end
        end
        ST_HOLD: begin
          // Run must drop before another multiply can be launched.
          if (!Run) begin
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign Aval = r_a;
  assign Bval = r_b;
  assign X    = r_x;
  assign busy = r_busy;
  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mult_sequencer: scoreboard bench for the shift-add multiply sequencer  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mult_sequencer;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic [7:0] S;
  logic [7:0] Aval;
  logic [7:0] Bval;
  logic       X;
  logic       busy;
  logic       done;

  int          n_vec = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  model_b;

  mult_sequencer #(.WIDTH(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .S            (S),
    .Aval         (Aval),
    .Bval         (Bval),
    .X            (X),
    .busy         (busy),
    .done         (done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exact signed product, sign-extended to 17 bits as {X,A,B}.
  function automatic logic [16:0] model_mul(input logic [7:0] b, input logic [7:0] m);
    logic signed [16:0] sb;
    logic signed [16:0] sm;
    logic signed [16:0] p;
    sb = $signed(b);
    sm = $signed(m);
    p  = sb * sm;
    return p;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [7:0] b);
    ClearA_LoadB = 1'b1;
    S            = b;
    tick();
    ClearA_LoadB = 1'b0;
    model_b      = b;
    chk("load_B", Bval, b);
    chk("load_A", Aval, 8'h00);
  endtask

  task automatic start(input logic [7:0] m, input logic clb);
    exp_q.push_back(model_mul(model_b, m));
    S            = m;
    Run          = 1'b1;
    ClearA_LoadB = clb;
    tick();
    ClearA_LoadB = 1'b0;
    S            = 8'($urandom);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
  endtask

  task automatic wait_done(input string tag);
    int          cyc;
    logic [16:0] e;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 4)  Run = 1'b0;
      if (cyc == 8)  chk({tag, "_midbusy"}, busy, 1);
      if (cyc == 9)  ClearA_LoadB = 1'b1;
      if (cyc == 10) ClearA_LoadB = 1'b0;
      if (cyc == 12) Run = 1'b1;
    end
    chk({tag, "_latency"}, cyc, 17);
    chk({tag, "_busy_off"}, busy, 0);
    chk({tag, "_pending"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_product"}, {X, Aval, Bval}, e);
      model_b = e[7:0];
    end
  endtask

  task automatic release_run();
    Run = 1'b0;
    tick();
    chk("release_done", done, 0);
  endtask

  initial begin
    Reset        = 1'b1;
    Run          = 1'b0;
    ClearA_LoadB = 1'b0;
    S            = 8'h00;
    model_b      = 8'h00;
    tick();
    tick();
    chk("rst_X", X, 0);
    chk("rst_A", Aval, 8'h00);
    chk("rst_B", Bval, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    Reset = 1'b0;
    tick();

    load(8'hFD);
    start(8'h07, 1'b0);
    wait_done("m7x-3");
    release_run();
    start(8'h02, 1'b0);
    wait_done("chain");
    release_run();

    load(8'h80);
    start(8'h80, 1'b0);
    wait_done("m-128sq");
    release_run();

    load(8'h00);
    start(8'h7F, 1'b0);
    wait_done("zero");
    release_run();

    // Run and ClearA_LoadB together: the multiply must use the old B.
    load(8'h05);
    start(8'h03, 1'b1);
    wait_done("run_prio");
    repeat (5) tick();
    chk("hold_done", done, 1);
    chk("hold_busy", busy, 0);
    chk("hold_B", Bval, 8'h0F);
    release_run();

    // Reset mid-multiply with Run held: a fresh multiply follows on B=0.
    load(8'h03);
    start(8'h05, 1'b0);
    repeat (5) tick();
    chk("mid_busy", busy, 1);
    Reset = 1'b1;
    tick();
    chk("midrst_X", X, 0);
    chk("midrst_A", Aval, 8'h00);
    chk("midrst_B", Bval, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    exp_q.delete();
    model_b = 8'h00;
    Reset   = 1'b0;
    S       = 8'h11;
    exp_q.push_back(model_mul(model_b, 8'h11));
    tick();
    chk("restart_busy", busy, 1);
    wait_done("restart");
    release_run();

    for (int i = 0; i < 4; i++) begin
      load(8'($urandom));
      start(8'($urandom), 1'b0);
      wait_done("rand");
      release_run();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
